// File: rtl/tt_scorer_pkg.sv
// Shared types and width helpers for the truth-table scorer.
// Holds the sweep FSM state enum and derived-width functions used by the
// scorer top and its popcount helper.
package tt_scorer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    APPLY  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } tt_state_e;

  // Bits needed to hold the values 0..n inclusive.
  function automatic int unsigned count_width(input int unsigned n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

  // Total score width: up to n_out matching bits on each of 2**n_in rows.
  function automatic int unsigned score_width(input int unsigned n_in,
                                              input int unsigned n_out);
    return count_width(n_out * (32'd1 << n_in));
  endfunction

  // Per-output counter width: up to 2**n_in matching rows.
  function automatic int unsigned perout_width(input int unsigned n_in);
    return n_in + 1;
  endfunction

endpackage

// File: rtl/truth_table_scorer_match_popcount.sv
// Counts the bit positions where a and b agree (popcount of ~(a ^ b)).
// Ports:
//   a, b   : N_OUT-bit operands (candidate response, target row)
//   cnt_c  : combinational number of equal bit positions
module match_popcount
  import tt_scorer_pkg::*;
#(
  parameter int unsigned N_OUT = 4
) (
  input  logic [N_OUT-1:0]                  a,
  input  logic [N_OUT-1:0]                  b,
  output logic [count_width(N_OUT)-1:0]     cnt_c
);

  localparam int unsigned CNT_W = count_width(N_OUT);

  always_comb begin
    cnt_c = '0;
    for (int unsigned i = 0; i < N_OUT; i++) begin
      cnt_c = cnt_c + CNT_W'(a[i] == b[i]);
    end
  end

endmodule

// File: rtl/truth_table_scorer.sv
// Sequential fitness evaluator: sweeps every input vector of a candidate
// circuit, holds each for SETTLE cycles, samples the response once and
// accumulates the number of output bits that agree with the target table.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   start          : begin a sweep (accepted only when idle)
//   abort          : cancel a running sweep, score cleared
//   busy           : sweep in progress
//   done           : one-cycle pulse, score valid
//   dut_in         : vector driven to the candidate
//   dut_out        : candidate response
//   tgt_addr       : target ROM address (mirrors dut_in)
//   tgt_data       : target row for tgt_addr
//   score          : total matching output bits
//   per_out_score  : per-output matching-row counts, output 0 in the LSBs
//                    (present only when TT_PEROUT_SCORE_EN is defined)
module truth_table_scorer
  import tt_scorer_pkg::*;
#(
  parameter int unsigned N_IN    = 4,
  parameter int unsigned N_OUT   = 4,
  parameter int unsigned SETTLE  = 4,
  parameter int unsigned SCORE_W = score_width(N_IN, N_OUT)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  output logic               busy,
  output logic               done,
  output logic [N_IN-1:0]    dut_in,
  input  logic [N_OUT-1:0]   dut_out,
  output logic [N_IN-1:0]    tgt_addr,
  input  logic [N_OUT-1:0]   tgt_data,
  output logic [SCORE_W-1:0] score
`ifdef TT_PEROUT_SCORE_EN
  ,
  output logic [N_OUT*perout_width(N_IN)-1:0] per_out_score
`endif
);

  localparam int unsigned VEC_W = N_IN + 1;
  localparam int unsigned CNT_W = count_width(SETTLE);
  localparam int unsigned PC_W  = count_width(N_OUT);

  localparam logic [VEC_W-1:0] LAST_VEC    = VEC_W'((1 << N_IN) - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE - 1);

  tt_state_e         state;
  tt_state_e         state_nxt;
  logic [VEC_W-1:0]  vec;
  logic [CNT_W-1:0]  settle_cnt;
  logic [PC_W-1:0]   match_cnt_c;
  logic              clr_c;
  logic              abrt_c;
  logic              acc_c;
  logic              last_c;

  match_popcount #(.N_OUT(N_OUT)) u_popcount (
    .a     (dut_out),
    .b     (tgt_data),
    .cnt_c (match_cnt_c)
  );

  assign dut_in   = vec[N_IN-1:0];
  assign tgt_addr = vec[N_IN-1:0];

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and datapath strobes; abort wins over the SAMPLE accumulation.
  always_comb begin
    state_nxt = state;
    clr_c     = 1'b0;
    abrt_c    = 1'b0;
    acc_c     = 1'b0;
    last_c    = (vec == LAST_VEC);
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = APPLY;
          clr_c     = 1'b1;
        end
      end
      APPLY: begin
        if (abort) begin
          state_nxt = IDLE;
          abrt_c    = 1'b1;
        end else if (settle_cnt == SETTLE_LAST) begin
          state_nxt = SAMPLE;
        end
      end
      SAMPLE: begin
        if (abort) begin
          state_nxt = IDLE;
          abrt_c    = 1'b1;
        end else begin
          acc_c     = 1'b1;
          state_nxt = last_c ? DONE : APPLY;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Vector, settle counter, score and status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy       <= 1'b0;
      done       <= 1'b0;
      vec        <= '0;
      settle_cnt <= '0;
      score      <= '0;
    end else begin
      busy <= (state_nxt == APPLY) || (state_nxt == SAMPLE);
      done <= (state_nxt == DONE);
      if (clr_c) begin
        vec        <= '0;
        settle_cnt <= '0;
        score      <= '0;
      end else if (abrt_c) begin
        settle_cnt <= '0;
        score      <= '0;
      end else if (acc_c) begin
        score      <= score + SCORE_W'(match_cnt_c);
        settle_cnt <= '0;
        if (!last_c) vec <= vec + VEC_W'(1);
      end else if (state == APPLY) begin
        settle_cnt <= settle_cnt + CNT_W'(1);
      end
    end
  end

`ifdef TT_PEROUT_SCORE_EN
  localparam int unsigned PO_W = perout_width(N_IN);

  logic [N_OUT-1:0]           eq_c;
  logic [N_OUT-1:0][PO_W-1:0] po_q;

  assign eq_c          = ~(dut_out ^ tgt_data);
  assign per_out_score = po_q;

  // One matching-row counter per output bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      po_q <= '0;
    end else if (clr_c || abrt_c) begin
      po_q <= '0;
    end else if (acc_c) begin
      for (int unsigned i = 0; i < N_OUT; i++) begin
        if (eq_c[i]) po_q[i] <= po_q[i] + PO_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_truth_table_scorer.sv
module tb_truth_table_scorer;

  localparam int NI = 4;
  localparam int NO = 4;
  localparam int NV = 16;
  localparam int S1 = 4;
  localparam int S2 = 2;
  localparam int SW = 7;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start, abort, start2, abort2;
  logic          busy, done, busy2, done2;
  logic [NI-1:0] dut_in, tgt_addr, dut2_in, tgt2_addr;
  logic [NO-1:0] dut_out, tgt_data, dut2_out, tgt2_data;
  logic [SW-1:0] score, score2;
`ifdef TT_PEROUT_SCORE_EN
  logic [NO*(NI+1)-1:0] po, po2;
`endif

  logic [NO-1:0] cand [NV];
  logic [NO-1:0] tgt  [NV];
  logic [NI-1:0] h1 [1:4] = '{default: '0};
  logic [NI-1:0] h2 [1:4] = '{default: '0};
  int d1, d2;

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  truth_table_scorer #(.N_IN(NI), .N_OUT(NO), .SETTLE(S1)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .busy(busy), .done(done), .dut_in(dut_in), .dut_out(dut_out),
    .tgt_addr(tgt_addr), .tgt_data(tgt_data), .score(score)
`ifdef TT_PEROUT_SCORE_EN
    , .per_out_score(po)
`endif
  );

  truth_table_scorer #(.N_IN(NI), .N_OUT(NO), .SETTLE(S2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .abort(abort2),
    .busy(busy2), .done(done2), .dut_in(dut2_in), .dut_out(dut2_out),
    .tgt_addr(tgt2_addr), .tgt_data(tgt2_data), .score(score2)
`ifdef TT_PEROUT_SCORE_EN
    , .per_out_score(po2)
`endif
  );

  // Candidates with d-cycle delay: response in cycle t reflects the input of cycle t-d.
  always @(posedge clk) begin
    h1[1] <= dut_in;
    h2[1] <= dut2_in;
    for (int i = 2; i <= 4; i++) begin
      h1[i] <= h1[i-1];
      h2[i] <= h2[i-1];
    end
  end

  always_comb begin
    if (d1 == 0) dut_out = cand[dut_in];
    else         dut_out = cand[h1[d1]];
    if (d2 == 0) dut2_out = cand[dut2_in];
    else         dut2_out = cand[h2[d2]];
    tgt_data  = tgt[tgt_addr];
    tgt2_data = tgt[tgt2_addr];
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Matching bits for vector v: the response seen at sampling time comes from
  // the vector applied d cycles earlier, i.e. v itself if d <= settle,
  // otherwise the previously applied vector.
  function automatic int vmatch(int v, int settle, int dly, int pre);
    int src;
    int n;
    src = (dly <= settle) ? v : ((v == 0) ? pre : v - 1);
    n = 0;
    for (int i = 0; i < NO; i++) if (cand[src][i] == tgt[v][i]) n++;
    return n;
  endfunction

  function automatic int partial(int nvec, int settle, int dly, int pre);
    int s;
    s = 0;
    for (int v = 0; v < nvec; v++) s += vmatch(v, settle, dly, pre);
    return s;
  endfunction

  function automatic int po_exp(int bitn);
    int n;
    n = 0;
    for (int v = 0; v < NV; v++) if (cand[v][bitn] == tgt[v][bitn]) n++;
    return n;
  endfunction

  // Reference model of the main scorer, tracked by cycles elapsed since start.
  bit m_run, m_busy, m_done;
  int m_k, m_score, m_in;

  initial begin
    m_run = 0; m_busy = 0; m_done = 0; m_k = 0; m_score = 0; m_in = 0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_run = 0; m_busy = 0; m_done = 0; m_k = 0; m_score = 0; m_in = 0;
      end else if (m_run) begin
        if (abort) begin
          m_run = 0; m_busy = 0; m_score = 0;
        end else begin
          m_k++;
          if (m_k == NV * (S1 + 1) + 1) begin
            m_run = 0; m_busy = 0; m_done = 1;
            m_score = partial(NV, S1, d1, 0);
          end else begin
            m_in    = (m_k - 1) / (S1 + 1);
            m_score = partial((m_k - 1) / (S1 + 1), S1, d1, 0);
          end
        end
      end else if (m_done) begin
        m_done = 0;
      end else if (start) begin
        m_run = 1; m_k = 1; m_busy = 1; m_in = 0; m_score = 0;
      end
    end
  end

  // Cycle-by-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        chk("busy", 64'(busy), 64'(m_busy));
        chk("done", 64'(done), 64'(m_done));
        chk("score", 64'(score), 64'(m_score));
        if (m_busy) begin
          chk("dut_in", 64'(dut_in), 64'(m_in));
          chk("tgt_addr", 64'(tgt_addr), 64'(m_in));
        end
`ifdef TT_PEROUT_SCORE_EN
        if (m_done)
          for (int i = 0; i < NO; i++)
            chk("per_out", 64'(po[i*(NI+1) +: (NI+1)]), 64'(po_exp(i)));
`endif
      end
    end
  end

  task automatic set_identity();
    for (int i = 0; i < NV; i++) begin
      cand[i] = NO'(i);
      tgt[i]  = NO'(i);
    end
  endtask

  // One sweep on the main scorer with optional abort, stray start and reset injections.
  task automatic do_run(input int abort_at, input int start_at, input int rst_at,
                        input int max_c, output int done_at, output int busy_n,
                        output int fin);
    done_at = -1; busy_n = 0; fin = -1;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int c = 1; c <= max_c; c++) begin
      abort = (c == abort_at);
      start = (c == start_at);
      if (c == rst_at) begin
        rst_n = 1'b0;
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_dut_in", 64'(dut_in), 64'd0);
        chk("rst_tgt_addr", 64'(tgt_addr), 64'd0);
        chk("rst_score", 64'(score), 64'd0);
      end
      @(negedge clk);
      if (busy) busy_n++;
      if (done) begin
        done_at = c;
        fin = int'(score);
      end
      @(posedge clk); #1;
      abort = 1'b0; start = 1'b0; rst_n = 1'b1;
      if (done_at >= 0 || c == rst_at) break;
    end
  endtask

  task automatic run2(output int done_at, output int sc);
    done_at = -1; sc = -1;
    @(posedge clk); #1 start2 = 1'b1;
    @(posedge clk); #1 start2 = 1'b0;
    for (int c = 1; c <= 80; c++) begin
      @(negedge clk);
      if (done2) begin
        done_at = c;
        sc = int'(score2);
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int da, bn, fs;
    int aa, mc;
    rst_n = 1'b1; start = 1'b0; abort = 1'b0; start2 = 1'b0; abort2 = 1'b0;
    d1 = 0; d2 = 0;
    set_identity();
    #3 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_dut_in", 64'(dut_in), 64'd0);
    chk("reset_tgt_addr", 64'(tgt_addr), 64'd0);
    chk("reset_score", 64'(score), 64'd0);
    chk("reset_score2", 64'(score2), 64'd0);
    rst_n = 1'b1;
    cmp_en = 1'b1;

    // Identity candidate against identity target.
    do_run(0, 0, 0, 120, da, bn, fs);
    chk("ident_done_cycle", 64'(da), 64'd81);
    chk("ident_busy_cycles", 64'(bn), 64'd80);
    chk("ident_score", 64'(fs), 64'd64);

    // Inverting candidate, twice: score must not accumulate across sweeps.
    for (int i = 0; i < NV; i++) cand[i] = ~NO'(i);
    do_run(0, 0, 0, 120, da, bn, fs);
    chk("inv_score_1", 64'(fs), 64'd0);
    do_run(0, 0, 0, 120, da, bn, fs);
    chk("inv_score_2", 64'(fs), 64'd0);

    // One flipped target bit.
    set_identity();
    tgt[5] = tgt[5] ^ 4'b0100;
    do_run(0, 0, 0, 120, da, bn, fs);
    chk("flip_score", 64'(fs), 64'd63);
`ifdef TT_PEROUT_SCORE_EN
    chk("flip_po0", 64'(po[4:0]), 64'd16);
    chk("flip_po1", 64'(po[9:5]), 64'd16);
    chk("flip_po2", 64'(po[14:10]), 64'd15);
    chk("flip_po3", 64'(po[19:15]), 64'd16);
`endif

    // Abort mid-sweep, then a fresh sweep completes normally.
    set_identity();
    do_run(30, 0, 0, 34, da, bn, fs);
    chk("abort_no_done", 64'(da), 64'hFFFF_FFFF_FFFF_FFFF);
    chk("abort_busy_cycles", 64'(bn), 64'd30);
    chk("abort_score", 64'(score), 64'd0);
    do_run(0, 0, 0, 120, da, bn, fs);
    chk("post_abort_done_cycle", 64'(da), 64'd81);
    chk("post_abort_score", 64'(fs), 64'd64);

    // Stray start while busy, then reset mid-sweep.
    do_run(0, 20, 40, 120, da, bn, fs);
    chk("rst_no_done", 64'(da), 64'hFFFF_FFFF_FFFF_FFFF);
    chk("rst_busy_cycles", 64'(bn), 64'd39);

    // Three-cycle candidate on the SETTLE=2 scorer: samples see the previous vector.
    d2 = 3;
    run2(da, fs);
    chk("slow_done_cycle", 64'(da), 64'd49);
    chk("slow_score_literal", 64'(fs), 64'd38);
    chk("slow_score_model", 64'(fs), 64'(partial(NV, S2, 3, 0)));
    d2 = 2;
    run2(da, fs);
    chk("fast_enough_score", 64'(fs), 64'd64);

    // Randomized candidates, targets, delays and aborts.
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < NV; i++) begin
        cand[i] = NO'($urandom);
        tgt[i]  = NO'($urandom);
      end
      d1 = int'($urandom_range(0, S1));
      if ($urandom_range(0, 2) == 0) begin
        aa = int'($urandom_range(1, 80));
        mc = aa + 3;
      end else begin
        aa = 0;
        mc = 120;
      end
      do_run(aa, 0, 0, mc, da, bn, fs);
      if (aa == 0) begin
        chk("rand_done_cycle", 64'(da), 64'd81);
        chk("rand_score", 64'(fs), 64'(partial(NV, S1, d1, 0)));
      end else begin
        chk("rand_abort_busy", 64'(bn), 64'(aa));
      end
    end

    repeat (3) @(posedge clk);
    cmp_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
